// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the CPU request/response handshake and the
// Avalon data-bus signals of mem_access_unit.
//   slave  : view used by mem_access_unit (accepts requests, masters the bus)
//   master : view used by the surrounding core / bus fabric / testbench
// Request side : req_valid, req_ready, req_op, req_addr, req_rt
// Response side: resp_valid, resp_data, resp_misaligned
// Avalon side  : address, read, write, byteenable, writedata, readdata,
//                waitrequest
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic [3:0]                req_op;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [31:0]               req_rt;
  logic                      resp_valid;
  logic [31:0]               resp_data;
  logic                      resp_misaligned;
  logic [ADDR_WIDTH-1:0]     address;
  logic                      read;
  logic                      write;
  logic [DATA_WIDTH/8-1:0]   byteenable;
  logic [DATA_WIDTH-1:0]     writedata;
  logic [DATA_WIDTH-1:0]     readdata;
  logic                      waitrequest;

  modport slave (
    input  req_valid, req_op, req_addr, req_rt, readdata, waitrequest,
    output req_ready, resp_valid, resp_data, resp_misaligned,
           address, read, write, byteenable, writedata
  );

  modport master (
    output req_valid, req_op, req_addr, req_rt, readdata, waitrequest,
    input  req_ready, resp_valid, resp_data, resp_misaligned,
           address, read, write, byteenable, writedata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential load/store lane unit between the MIPS memory
// stage and an Avalon data bus (DATA_WIDTH 32 or 64, CPU side 32-bit).
// One request at a time: alignment check, a single bus transaction with
// lane-placed byteenable/writedata (held while waitrequest), then a one-cycle
// response carrying the extracted / extended / LWL-LWR merged load result.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - mem_access_unit_if.slave (request, response and Avalon signals)
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_unit_if.slave    bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = $clog2(NB);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  // Unknown opcodes behave exactly like LW, so fold them at accept time.
  function automatic logic [3:0] norm_op(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
      OP_SB, OP_SH, OP_SW: return op;
      default:             return OP_LW;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return |a;
      default:              return 1'b0;
    endcase
  endfunction

  // LWL/LWR always touch the whole enclosing 32-bit word.
  function automatic logic [NB-1:0] lane_enables(input logic [3:0] op, input logic [L-1:0] k);
    logic [L-1:0] w;
    w = k & ~L'(3);
    case (op)
      OP_LB, OP_LBU, OP_SB: return NB'(1'b1) << k;
      OP_LH, OP_LHU, OP_SH: return NB'(2'b11) << k;
      default:              return NB'(4'hF) << w;
    endcase
  endfunction

  // Store data is replicated across the bus; byteenable picks the lanes.
  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [3:0] op, input logic [31:0] rt);
    case (op)
      OP_SB:   return {NB{rt[7:0]}};
      OP_SH:   return {(NB/2){rt[15:0]}};
      OP_SW:   return {(NB/4){rt}};
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] load_result(input logic [3:0] op, input logic [L-1:0] k,
                                              input logic [31:0] rt,
                                              input logic [DATA_WIDTH-1:0] rd);
    logic [L-1:0]          w;
    logic [1:0]            o;
    logic [DATA_WIDTH-1:0] rd_k;
    logic [DATA_WIDTH-1:0] rd_w;
    logic [31:0]           lane;
    logic [31:0]           word;
    logic [4:0]            sh_l;
    logic [4:0]            sh_r;
    w    = k & ~L'(3);
    o    = k[1:0];
    rd_k = rd >> {k, 3'b000};
    rd_w = rd >> {w, 3'b000};
    lane = rd_k[31:0];
    word = rd_w[31:0];
    sh_l = {o, 3'b000};
    sh_r = {2'd3 - o, 3'b000};
    case (op)
      OP_LB:   return {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  return {24'h0, lane[7:0]};
      OP_LH:   return {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  return {16'h0, lane[15:0]};
      OP_LWL:  return (word << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
      OP_LWR:  return (word >> sh_r) | (rt & ~(32'hFFFF_FFFF >> sh_r));
      default: return lane;
    endcase
  endfunction

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [L-1:0] k_q;
  logic [31:0] rt_q;

  logic [3:0]  req_op_n;
  logic        req_mis;
  logic [L-1:0] req_k;

  always_comb begin
    req_op_n = norm_op(bus.req_op);
    req_mis  = is_misaligned(req_op_n, bus.req_addr[1:0]);
    req_k    = bus.req_addr[L-1:0];
  end

  assign bus.req_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      op_q                <= '0;
      k_q                 <= '0;
      rt_q                <= '0;
      bus.read            <= 1'b0;
      bus.write           <= 1'b0;
      bus.resp_valid      <= 1'b0;
      bus.resp_misaligned <= 1'b0;
      bus.resp_data       <= '0;
      bus.address         <= '0;
      bus.byteenable      <= '0;
      bus.writedata       <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q <= req_op_n;
            k_q  <= req_k;
            rt_q <= bus.req_rt;
            if (req_mis) begin
              state               <= S_FAULT;
              bus.resp_valid      <= 1'b1;
              bus.resp_misaligned <= 1'b1;
              bus.resp_data       <= '0;
            end else begin
              state          <= S_BUS;
              bus.address    <= bus.req_addr & ~ADDR_WIDTH'(NB - 1);
              bus.byteenable <= lane_enables(req_op_n, req_k);
              bus.writedata  <= store_data(req_op_n, bus.req_rt);
              bus.read       <= ~is_store(req_op_n);
              bus.write      <= is_store(req_op_n);
            end
          end
        end
        S_BUS: begin
          // Result is formed straight from readdata at the completing edge so
          // resp_data is already registered when resp_valid rises.
          if (!bus.waitrequest) begin
            state               <= S_RESP;
            bus.read            <= 1'b0;
            bus.write           <= 1'b0;
            bus.resp_valid      <= 1'b1;
            bus.resp_misaligned <= 1'b0;
            bus.resp_data       <= is_store(op_q) ? 32'h0
                                   : load_result(op_q, k_q, rt_q, bus.readdata);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential load/store lane unit between the MIPS core's memory stage and the Avalon data bus. It accepts one memory request at a time, checks alignment, and drives a single bus transaction with correct `byteenable`/`writedata`, stalling on `waitrequest`. It then returns the extracted, sign/zero-extended or LWL/LWR-merged result. The bus width is parametrised (32 or 64 bits); the CPU side stays 32-bit.

## Interface
- `DATA_WIDTH`, 32, bus data width; legal values 32 or 64. `L = log2(DATA_WIDTH/8)`.
- `ADDR_WIDTH`, 32, byte address width.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `req_op` in 4: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW. Other codes are treated as LW.
- `req_addr` in ADDR_WIDTH: effective byte address.
- `req_rt` in 32: rt value; store data, and merge source for LWL/LWR.
- `resp_valid` out 1: one-cycle result pulse.
- `resp_data` out 32: load result; 0 for stores and faults.
- `resp_misaligned` out 1: qualifies `resp_valid`; set for an address exception.
- `address` out ADDR_WIDTH: `req_addr` with its low L bits cleared.
- `read`, `write` out 1: Avalon strobes.
- `byteenable` out DATA_WIDTH/8: active lanes.
- `writedata` out DATA_WIDTH: store data placed in lanes.
- `readdata` in DATA_WIDTH: read return.
- `waitrequest` in 1: bus stall.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, latch op, addr and rt.
    - Misaligned request → RESP_FAULT.
    - Otherwise → BUS.
  - BUS: `read` (loads) or `write` (stores) held high.
    - `address`, `byteenable` and `writedata` stay constant while `waitrequest`=1.
    - When `waitrequest`=0: register `readdata` and → RESP.
  - RESP: `resp_valid`=1 for one cycle → IDLE.
  - RESP_FAULT: `resp_valid`=1, `resp_misaligned`=1, `resp_data`=0 → IDLE. No bus strobe is ever asserted for a fault.
- Misaligned conditions:
  - LH/LHU/SH with `addr[0]`=1.
  - LW/SW with `addr[1:0]`≠0.
  - Byte ops and LWL/LWR are never misaligned.
- Lane index `k = addr[L-1:0]`. Byte lane `k` is `data[8k+7:8k]`.
- Byte enables:
  - Byte ops: lane k only.
  - Half ops: lanes k, k+1.
  - Word ops: lanes k..k+3.
  - LWL/LWR: lanes of the enclosing 32-bit word `w = k & ~3`.
- Loads:
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
  - LW returns lanes k..k+3.
- LWL/LWR operate on word `W` at lanes w..w+3, with `o = addr[1:0]`:
  - LWL = `(W << 8o) | (rt & (2^(8o)-1))`.
  - LWR = `(W >> 8(3-o)) | (rt & ~(32'hFFFFFFFF >> 8(3-o)))`.
- Stores: `rt[7:0]`, `rt[15:0]` or `rt` is replicated into every lane group; `byteenable` selects the lanes actually written.
- Reset (including mid-transaction): state → IDLE on the next edge.
  - `read`, `write`, `resp_valid`, `resp_misaligned` → 0; `byteenable` and `writedata` → 0.
  - No response is issued for the aborted request.
  - `req_ready`=1 from the first cycle after reset deasserts.

## Timing
- Accept edge T.
  - BUS occupies cycles T+1 .. T+1+n, where n is the number of `waitrequest`-high cycles.
  - `resp_valid` is high in cycle T+2+n. Minimum latency is 2 cycles.
- Fault response: `resp_valid` in cycle T+1.
- `req_ready` is low from T+1 until the cycle after `resp_valid`. Back-to-back requests therefore have one request every 3+n cycles.
- `resp_data` and `resp_misaligned` are registered outputs, valid only while `resp_valid`=1. They hold their last value otherwise.
- No response backpressure: the consumer must take `resp_valid` when it is presented.
- `req_valid` seen during `reset` is ignored.

## Test plan
- LB at addr 0x103 (DW=32), `readdata`=0x80FF1234, `waitrequest`=0:
  - `byteenable`=0001? No: `byteenable`=1000, `read` high for 1 cycle.
  - `resp_data`=0xFFFFFF80 at T+2.
  - Same stimulus with LBU → 0x00000080.
- LH at 0x102 with `waitrequest` high for 3 cycles, `readdata`=0x8001_xxxx:
  - Bus signals stable for 4 cycles.
  - `resp_data`=0xFFFF8001 at T+5.
- SW at 0x101:
  - `resp_valid` & `resp_misaligned` at T+1, `resp_data`=0.
  - `write` never asserted.
- LWL o=2 and LWR o=1 with `readdata`=0xAABBCCDD, `rt`=0x11223344:
  - LWL → 0xCCDD3344.
  - LWR → 0x1122AABB.
- DW=64, SH at 0x106, `rt`=0x0000BEEF:
  - `address`=0x100, `byteenable`=11000000.
  - `writedata[63:48]`=0xBEEF.
- Reset asserted during BUS (`waitrequest`=1):
  - Next cycle `read`=0, `req_ready`=1.
  - No `resp_valid`.
  - A subsequent LW completes normally.
